// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall control: load-use or RAW stall, branch flush and SRAM wait freeze.
// Define HAZARD_FORWARDING_EN when EX has a forwarding unit (only load-use stalls).
module hazard_stall_unit #(
    parameter int unsigned MEM_WAIT_CYCLES = 5,
    parameter int unsigned CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1_addr,
    input  logic [3:0]       id_src2_addr,
    input  logic             id_src1_valid,
    input  logic             id_src2_valid,
    input  logic [3:0]       ex_dest_reg,
    input  logic             ex_wb_enable,
    input  logic             ex_mem_read_en,
    input  logic [3:0]       mem_dest_reg,
    input  logic             mem_wb_enable,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             perf_clr,
    output logic             hazard_freeze,
    output logic             pipe_freeze,
    output logic             if_flush,
    output logic             id_flush,
    output logic             sram_ready,
    output logic [15:0]      stall_cycles
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // BUSY spans MEM_WAIT_CYCLES-2 cycles so the request cycle plus BUSY plus DONE
    // add up to exactly MEM_WAIT_CYCLES.
    localparam logic [CNT_W-1:0] CntLoad =
        (MEM_WAIT_CYCLES > 3) ? CNT_W'(MEM_WAIT_CYCLES - 3) : '0;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_q, stall_d;

    logic ex_hit1, ex_hit2;
    logic load_use;
    logic hz;

    // Memory-wait FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (mem_req) begin
                    if (MEM_WAIT_CYCLES == 2) begin
                        state_d = StDone;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                // A request seen here still belongs to the completing access.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hazard detection
    assign ex_hit1  = id_src1_valid && (id_src1_addr == ex_dest_reg);
    assign ex_hit2  = id_src2_valid && (id_src2_addr == ex_dest_reg);
    assign load_use = ex_mem_read_en && ex_wb_enable && (ex_hit1 || ex_hit2);

`ifdef HAZARD_FORWARDING_EN
    assign hz = load_use;
`else
    logic mem_hit1, mem_hit2;
    assign mem_hit1 = id_src1_valid && (id_src1_addr == mem_dest_reg);
    assign mem_hit2 = id_src2_valid && (id_src2_addr == mem_dest_reg);
    // Without forwarding any pending write-back to a source register must stall.
    assign hz = load_use
             || (ex_wb_enable && (ex_hit1 || ex_hit2))
             || (mem_wb_enable && (mem_hit1 || mem_hit2));
`endif

    // Output priority: memory freeze, then branch flush, then hazard stall.
    always_comb begin
        pipe_freeze   = ((state_q == StIdle) && mem_req) || (state_q == StBusy);
        sram_ready    = (state_q == StDone);
        hazard_freeze = 1'b0;
        if_flush      = 1'b0;
        id_flush      = 1'b0;
        if (!pipe_freeze) begin
            if (branch_taken) begin
                if_flush = 1'b1;
                id_flush = 1'b1;
            end else if (hz) begin
                hazard_freeze = 1'b1;
                id_flush      = 1'b1;
            end
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_d = stall_q;
        if (perf_clr) begin
            stall_d = '0;
        end else if ((pipe_freeze || hazard_freeze) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios then random stimulus,
// all checked against an access-age / counter reference model.
module tb_hazard_stall_unit;

    localparam int MEM = 5;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  id_src1_addr, id_src2_addr;
    logic        id_src1_valid, id_src2_valid;
    logic [3:0]  ex_dest_reg;
    logic        ex_wb_enable, ex_mem_read_en;
    logic [3:0]  mem_dest_reg;
    logic        mem_wb_enable;
    logic        branch_taken, mem_req, perf_clr;
    logic        hazard_freeze, pipe_freeze, if_flush, id_flush, sram_ready;
    logic [15:0] stall_cycles;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: age of the current access in cycles (-1 = none), stall count.
    int m_age    = -1;
    int m_stalls = 0;
    int cur_age  = -1;
    bit cur_stall = 1'b0;

    hazard_stall_unit #(
        .MEM_WAIT_CYCLES(MEM),
        .CNT_W          (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_src1_addr  (id_src1_addr),
        .id_src2_addr  (id_src2_addr),
        .id_src1_valid (id_src1_valid),
        .id_src2_valid (id_src2_valid),
        .ex_dest_reg   (ex_dest_reg),
        .ex_wb_enable  (ex_wb_enable),
        .ex_mem_read_en(ex_mem_read_en),
        .mem_dest_reg  (mem_dest_reg),
        .mem_wb_enable (mem_wb_enable),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .perf_clr      (perf_clr),
        .hazard_freeze (hazard_freeze),
        .pipe_freeze   (pipe_freeze),
        .if_flush      (if_flush),
        .id_flush      (id_flush),
        .sram_ready    (sram_ready),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        id_src1_addr   = 4'd0;
        id_src2_addr   = 4'd0;
        id_src1_valid  = 1'b0;
        id_src2_valid  = 1'b0;
        ex_dest_reg    = 4'd0;
        ex_wb_enable   = 1'b0;
        ex_mem_read_en = 1'b0;
        mem_dest_reg   = 4'd0;
        mem_wb_enable  = 1'b0;
        branch_taken   = 1'b0;
        mem_req        = 1'b0;
        perf_clr       = 1'b0;
    endtask

    function automatic bit model_stall_cond();
        bit s1e, s2e, s1m, s2m, lu, raw;
        s1e = id_src1_valid && (id_src1_addr == ex_dest_reg);
        s2e = id_src2_valid && (id_src2_addr == ex_dest_reg);
        s1m = id_src1_valid && (id_src1_addr == mem_dest_reg);
        s2m = id_src2_valid && (id_src2_addr == mem_dest_reg);
        lu  = ex_mem_read_en && ex_wb_enable && (s1e || s2e);
        raw = (ex_wb_enable && (s1e || s2e)) || (mem_wb_enable && (s1m || s2m));
        return FWD ? lu : (lu || raw);
    endfunction

    // Mid-cycle: compare every output with the model.
    task automatic sample(input string tag);
        int age;
        bit epf, erdy, ehz, eif, eid, ehf;
        #4;
        if (!rst) begin
            m_age    = -1;
            m_stalls = 0;
        end
        age  = (m_age < 0 && mem_req) ? 0 : m_age;
        epf  = (age >= 0) && (age < MEM - 1);
        erdy = (age == MEM - 1);
        ehz  = model_stall_cond();
        eif  = !epf && branch_taken;
        eid  = !epf && (branch_taken || ehz);
        ehf  = !epf && !branch_taken && ehz;
        cur_age   = age;
        cur_stall = epf || ehf;
        chk({tag, ".pipe_freeze"},   {15'd0, pipe_freeze},   {15'd0, epf});
        chk({tag, ".sram_ready"},    {15'd0, sram_ready},    {15'd0, erdy});
        chk({tag, ".hazard_freeze"}, {15'd0, hazard_freeze}, {15'd0, ehf});
        chk({tag, ".if_flush"},      {15'd0, if_flush},      {15'd0, eif});
        chk({tag, ".id_flush"},      {15'd0, id_flush},      {15'd0, eid});
        chk({tag, ".stall_cycles"},  stall_cycles,           m_stalls[15:0]);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            if (perf_clr) m_stalls = 0;
            else if (cur_stall && m_stalls < 65535) m_stalls++;
            if (cur_age < 0) m_age = -1;
            else m_age = (cur_age == MEM - 1) ? -1 : cur_age + 1;
        end
        #1;
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with a pending request: FSM must not move.
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample("reset");
            chk("reset.sram_ready", {15'd0, sram_ready}, 16'd0);
            chk("reset.stall", stall_cycles, 16'd0);
            advance();
        end

        // Release with request held: freeze T..T+3, ready T+4, new access at T+5.
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample("memwait");
            chk("memwait.freeze", {15'd0, pipe_freeze}, {15'd0, (i < 4 || i == 5)});
            chk("memwait.ready",  {15'd0, sram_ready},  {15'd0, (i == 4)});
            advance();
        end
        mem_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample("memwait_tail");
            advance();
        end

        // Branch during an access: flush only once the access completes.
        mem_req = 1'b1;
        sample("brwait_req");
        advance();
        mem_req      = 1'b0;
        branch_taken = 1'b1;
        for (int i = 1; i < 5; i++) begin
            sample("brwait");
            chk("brwait.if_flush", {15'd0, if_flush}, {15'd0, (i == 4)});
            advance();
        end
        set_idle();

        // Load-use hazard after clearing the counter.
        perf_clr = 1'b1;
        sample("clr");
        advance();
        perf_clr       = 1'b0;
        ex_mem_read_en = 1'b1;
        ex_wb_enable   = 1'b1;
        ex_dest_reg    = 4'd3;
        id_src2_addr   = 4'd3;
        id_src2_valid  = 1'b1;
        sample("loaduse");
        chk("loaduse.hazard_freeze", {15'd0, hazard_freeze}, 16'd1);
        chk("loaduse.id_flush",      {15'd0, id_flush},      16'd1);
        advance();
        set_idle();
        sample("loaduse_after");
        chk("loaduse.stall_cycles", stall_cycles, 16'd1);
        chk("loaduse.released", {15'd0, hazard_freeze}, 16'd0);
        advance();

        // Branch beats hazard.
        ex_mem_read_en = 1'b1;
        ex_wb_enable   = 1'b1;
        ex_dest_reg    = 4'd3;
        id_src2_addr   = 4'd3;
        id_src2_valid  = 1'b1;
        branch_taken   = 1'b1;
        sample("br_vs_hz");
        chk("br_vs_hz.if_flush",      {15'd0, if_flush},      16'd1);
        chk("br_vs_hz.id_flush",      {15'd0, id_flush},      16'd1);
        chk("br_vs_hz.hazard_freeze", {15'd0, hazard_freeze}, 16'd0);
        advance();
        set_idle();

        // RAW against the EX/MEM destination only stalls without forwarding.
        mem_wb_enable = 1'b1;
        mem_dest_reg  = 4'd7;
        id_src1_addr  = 4'd7;
        id_src1_valid = 1'b1;
        sample("raw_mem");
        chk("raw_mem.hazard_freeze", {15'd0, hazard_freeze}, {15'd0, !FWD});
        advance();
        set_idle();

        // Random stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 99) != 0);
            id_src1_addr   = 4'($urandom_range(0, 3));
            id_src2_addr   = 4'($urandom_range(0, 3));
            id_src1_valid  = 1'($urandom_range(0, 1));
            id_src2_valid  = 1'($urandom_range(0, 1));
            ex_dest_reg    = 4'($urandom_range(0, 3));
            ex_wb_enable   = 1'($urandom_range(0, 1));
            ex_mem_read_en = 1'($urandom_range(0, 1));
            mem_dest_reg   = 4'($urandom_range(0, 3));
            mem_wb_enable  = 1'($urandom_range(0, 1));
            branch_taken   = ($urandom_range(0, 3) == 0);
            mem_req        = ($urandom_range(0, 2) == 0);
            perf_clr       = ($urandom_range(0, 39) == 0);
            sample("random");
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
